// File: rtl/flag_event_counter.sv
// Counts rising edges of each of three comparator flags over a WINDOW-cycle sampling window,
// framed by a START/DONE/ACK handshake. Define FLAG_STICKY_EN to add the STICKY output.
module flag_event_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [2:0]       IN_FLAGS,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CNT2,
  output logic [CNT_W-1:0] CNT1,
`ifdef FLAG_STICKY_EN
  output logic [CNT_W-1:0] CNT0,
  output logic [2:0]       STICKY
`else
  output logic [CNT_W-1:0] CNT0
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [7:0]       LAST_CYCLE = 8'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]              prev_q, prev_d;
  logic [7:0]              win_q, win_d;
  logic [2:0]              rise;
`ifdef FLAG_STICKY_EN
  logic [2:0]              sticky_q, sticky_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    win_d    = win_q;
    rise     = 3'b000;
`ifdef FLAG_STICKY_EN
    sticky_d = sticky_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          prev_d   = 3'b000;
          win_d    = 8'd0;
`ifdef FLAG_STICKY_EN
          sticky_d = 3'b000;
`endif
        end
      end
      ST_RUN: begin
        // The window advances every cycle; only valid samples touch prev and the counts.
        win_d = win_q + 8'd1;
        if (IN_VALID) begin
          rise = IN_FLAGS & ~prev_q;
          for (int i = 0; i < 3; i++) begin
            if (rise[i] && (cnt_q[i] != CNT_MAX)) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          prev_d = IN_FLAGS;
`ifdef FLAG_STICKY_EN
          sticky_d = sticky_q | IN_FLAGS;
`endif
        end
        if (win_q == LAST_CYCLE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ACK) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 3'b000;
      win_q    <= 8'd0;
`ifdef FLAG_STICKY_EN
      sticky_q <= 3'b000;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      win_q    <= win_d;
`ifdef FLAG_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign CNT2 = cnt_q[2];
  assign CNT1 = cnt_q[1];
  assign CNT0 = cnt_q[0];
`ifdef FLAG_STICKY_EN
  assign STICKY = sticky_q;
`endif

endmodule
